// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the "001" sequence front end.
//   ser_state_t     : serializer FSM state encoding
//   SER_IDLE_LEVEL  : level driven on sout when no bit is being sent.
//                     It is high so that idle time can never complete a
//                     0-0-1 pattern at the detector input.
// ---------------------------------------------------------------------------
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SHIFT  = 2'b01,
      PARITY = 2'b10
   } ser_state_t;

   localparam logic SER_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/seq_bit_serializer.sv
// ---------------------------------------------------------------------------
// seq_bit_serializer
// Parallel-to-serial front end for the "001" sequence detector. Accepts
// WIDTH-bit words over a valid/ready handshake and sends them out one bit
// per clock on sout, qualified by sout_valid. Back-to-back words stream
// without a gap when din_valid is presented during the final bit.
//
// Parameters:
//   WIDTH     : word width, 2..32
//   MSB_FIRST : 1 = din[WIDTH-1] goes out first, 0 = din[0] goes out first
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   din        in   parallel word, sampled only on a transfer edge
//   din_valid  in   din holds a word to transfer
//   din_ready  out  word can be accepted this cycle (combinational,
//                   depends on state and counter only)
//   sout       out  serial bit, high when idle (registered)
//   sout_valid out  sout carries a data or parity bit (registered)
//   busy       out  a word is in flight (registered)
//
// Build option:
//   SER_PARITY_EN : when defined, an even-parity bit (XOR of the word) is
//                   sent after the last data bit, making the word period
//                   WIDTH+1 cycles.
// ---------------------------------------------------------------------------
module seq_bit_serializer
   import seq_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   ser_state_t       state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sout_q, sout_d;
   logic             sout_valid_q, sout_valid_d;
   logic             busy_q;
`ifdef SER_PARITY_EN
   logic             parity_q, parity_d;
`endif

   logic             load;
   logic             load_first;
   logic [WIDTH-1:0] load_rest;
   logic             shift_bit;
   logic [WIDTH-1:0] shift_rest;

   // The first bit of a new word goes straight into the sout register on
   // the transfer edge, so the shift register only keeps the bits that
   // still have to follow. The counter holds how many of those remain.
   always_comb begin
      if (MSB_FIRST) begin
         load_first = din[WIDTH-1];
         load_rest  = din << 1;
         shift_bit  = shreg_q[WIDTH-1];
         shift_rest = shreg_q << 1;
      end else begin
         load_first = din[0];
         load_rest  = din >> 1;
         shift_bit  = shreg_q[0];
         shift_rest = shreg_q >> 1;
      end
   end

   // Ready opens only in cycles where the next edge would otherwise leave
   // the line idle: in IDLE, on the final bit of the word, or on the
   // parity cycle when parity is built in.
   always_comb begin
      din_ready = 1'b0;
      case (state_q)
         IDLE:   din_ready = 1'b1;
`ifdef SER_PARITY_EN
         SHIFT:  din_ready = 1'b0;
`else
         SHIFT:  din_ready = (cnt_q == '0);
`endif
         PARITY: din_ready = 1'b1;
         default: din_ready = 1'b0;
      endcase
   end

   assign load = din_valid && din_ready;

   // Next-state and next-output logic. Every exit from SHIFT/PARITY either
   // reloads a new word (gapless stream) or parks sout at the idle level.
   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      cnt_d        = cnt_q;
      sout_d       = sout_q;
      sout_valid_d = sout_valid_q;
`ifdef SER_PARITY_EN
      parity_d     = parity_q;
`endif

      if (load) begin
         state_d      = SHIFT;
         shreg_d      = load_rest;
         cnt_d        = CNT_LAST;
         sout_d       = load_first;
         sout_valid_d = 1'b1;
`ifdef SER_PARITY_EN
         parity_d     = ^din;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               sout_d       = SER_IDLE_LEVEL;
               sout_valid_d = 1'b0;
            end
            SHIFT: begin
               if (cnt_q != '0) begin
                  sout_d  = shift_bit;
                  shreg_d = shift_rest;
                  cnt_d   = cnt_q - 1'b1;
               end else begin
`ifdef SER_PARITY_EN
                  state_d      = PARITY;
                  sout_d       = parity_q;
                  sout_valid_d = 1'b1;
`else
                  state_d      = IDLE;
                  sout_d       = SER_IDLE_LEVEL;
                  sout_valid_d = 1'b0;
`endif
               end
            end
            default: begin
               state_d      = IDLE;
               sout_d       = SER_IDLE_LEVEL;
               sout_valid_d = 1'b0;
            end
         endcase
      end
   end

   // State and output registers. Reset abandons any word in flight and
   // forces the line back to the idle level without waiting for a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         shreg_q      <= '0;
         cnt_q        <= '0;
         sout_q       <= SER_IDLE_LEVEL;
         sout_valid_q <= 1'b0;
         busy_q       <= 1'b0;
`ifdef SER_PARITY_EN
         parity_q     <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         cnt_q        <= cnt_d;
         sout_q       <= sout_d;
         sout_valid_q <= sout_valid_d;
         busy_q       <= (state_d != IDLE);
`ifdef SER_PARITY_EN
         parity_q     <= parity_d;
`endif
      end
   end

   assign sout       = sout_q;
   assign sout_valid = sout_valid_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// ---------------------------------------------------------------------------
// tb_seq_bit_serializer
// Self-checking bench for seq_bit_serializer. Two instances (MSB-first and
// LSB-first) share the same inputs. A queue-based reference model predicts
// the serial stream of each; a valid-gated "001" detector model watches the
// MSB-first stream. Honours SER_PARITY_EN when defined.
// ---------------------------------------------------------------------------
module tb_seq_bit_serializer;

`ifdef SER_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int W = 8;
   localparam int P = W + PAR;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] din;
   logic         din_valid;
   logic         ready_m, sout_m, valid_m, busy_m;
   logic         ready_l, sout_l, valid_l, busy_l;

   int total = 0;
   int bad   = 0;
   int cycle = 0;

   // Reference model: bits still to be shown, front = current cycle's bit
   logic q_m[$];
   logic q_l[$];

   // Values observed mid-cycle by the last apply_stimulus call
   logic obs_ready, obs_valid, obs_sout_m, obs_sout_l;

   // Detector model (valid bits only)
   logic [2:0] det_hist;
   int         det_len = 0;
   int         det_count = 0;

   typedef struct {
      logic         v;
      logic [W-1:0] d;
      logic         e_sout;
      logic         e_valid;
      logic         e_ready;
   } vec_t;

   vec_t tbl[11];

   seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
      .din_ready(ready_m), .sout(sout_m), .sout_valid(valid_m), .busy(busy_m)
   );

   seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
      .din_ready(ready_l), .sout(sout_l), .sout_valid(valid_l), .busy(busy_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic push_word(input logic [W-1:0] w);
      for (int i = 0; i < W; i++) begin
         q_m.push_back(w[W-1-i]);
         q_l.push_back(w[i]);
      end
      if (PAR == 1) begin
         q_m.push_back(^w);
         q_l.push_back(^w);
      end
   endtask

   // One clock cycle: drive inputs mid-cycle, compare all outputs against
   // the model, step the model across the rising edge.
   task automatic apply_stimulus(input logic v, input logic [W-1:0] d);
      logic e_ready, xfer;
      din_valid = v;
      din       = d;
      #1;
      e_ready = (q_m.size() <= 1);
      check_output("ready_msb", ready_m, e_ready);
      check_output("ready_lsb", ready_l, e_ready);
      check_output("valid_msb", valid_m, q_m.size() != 0);
      check_output("valid_lsb", valid_l, q_l.size() != 0);
      check_output("busy_msb",  busy_m,  q_m.size() != 0);
      check_output("busy_lsb",  busy_l,  q_l.size() != 0);
      check_output("sout_msb",  sout_m,  (q_m.size() != 0) ? q_m[0] : 1'b1);
      check_output("sout_lsb",  sout_l,  (q_l.size() != 0) ? q_l[0] : 1'b1);
      obs_ready  = ready_m;
      obs_valid  = valid_m;
      obs_sout_m = sout_m;
      obs_sout_l = sout_l;
      if (valid_m) begin
         det_hist = {det_hist[1:0], sout_m};
         det_len++;
         if (det_len >= 3 && det_hist == 3'b001) det_count++;
      end else begin
         det_len = 0;
      end
      xfer = v && e_ready;
      @(posedge clk);
      if (q_m.size() != 0) void'(q_m.pop_front());
      if (q_l.size() != 0) void'(q_l.pop_front());
      if (xfer) push_word(d);
      @(negedge clk);
      cycle++;
   endtask

   initial begin
      logic [W-1:0] w;
      logic [W-1:0] col_m, col_l;
      int           rdy_cnt, val_cnt;

      rst_n     = 1'b0;
      din_valid = 1'b0;
      din       = '0;
      det_hist  = 3'b111;
      repeat (2) @(negedge clk);
      #1;
      check_output("reset_sout",  sout_m,  1'b1);
      check_output("reset_valid", valid_m, 1'b0);
      check_output("reset_ready", ready_m, 1'b1);
      check_output("reset_busy",  busy_l,  1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle after reset release: line high, nothing detected
      for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 8'h5A);
      check_int("idle_det", det_count, 0);

      // Table: 8'h20 MSB-first, cycle by cycle
      w = 8'h20;
      for (int i = 0; i < 11; i++) begin
         tbl[i].v       = (i == 0);
         tbl[i].d       = (i == 0) ? w : 8'hFF;
         tbl[i].e_sout  = 1'b1;
         tbl[i].e_valid = 1'b0;
         tbl[i].e_ready = 1'b1;
         if (i >= 1 && i <= W) begin
            tbl[i].e_sout  = w[W-i];
            tbl[i].e_valid = 1'b1;
            tbl[i].e_ready = (PAR == 0) && (i == W);
         end
         if (PAR == 1 && i == W + 1) begin
            tbl[i].e_sout  = ^w;
            tbl[i].e_valid = 1'b1;
            tbl[i].e_ready = 1'b1;
         end
      end
      det_count = 0;
      for (int i = 0; i < 11; i++) begin
         apply_stimulus(tbl[i].v, tbl[i].d);
         check_output($sformatf("tbl%0d_sout", i),  obs_sout_m, tbl[i].e_sout);
         check_output($sformatf("tbl%0d_valid", i), obs_valid,  tbl[i].e_valid);
         check_output($sformatf("tbl%0d_ready", i), obs_ready,  tbl[i].e_ready);
      end
      check_int("det_0x20", det_count, 1 + PAR);

      // Back-to-back 8'h01 then 8'hFF with din_valid held
      apply_stimulus(1'b1, 8'h01);
      rdy_cnt = 0;
      val_cnt = 0;
      for (int i = 1; i <= 2 * P; i++) begin
         apply_stimulus(i < 2 * P, 8'hFF);
         if (obs_ready) rdy_cnt++;
         if (obs_valid) val_cnt++;
      end
      check_int("b2b_ready_cycles", rdy_cnt, 2);
      check_int("b2b_valid_bits", val_cnt, 2 * P);
      repeat (2) apply_stimulus(1'b0, 8'h00);

      // 8'hB4 in both bit orders
      apply_stimulus(1'b1, 8'hB4);
      col_m = '0;
      col_l = '0;
      for (int i = 0; i < W; i++) begin
         apply_stimulus(1'b0, 8'h00);
         col_m = {col_m[W-2:0], obs_sout_m};
         col_l = {col_l[W-2:0], obs_sout_l};
      end
      check_int("b4_msb_stream", col_m, 8'hB4);
      check_int("b4_lsb_stream", col_l, 8'h2D);
      repeat (PAR + 2) apply_stimulus(1'b0, 8'h00);

      // Reset in the middle of a word
      apply_stimulus(1'b1, 8'h00);
      repeat (3) apply_stimulus(1'b0, 8'h00);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("midrst_sout_msb",  sout_m,  1'b1);
      check_output("midrst_sout_lsb",  sout_l,  1'b1);
      check_output("midrst_valid",     valid_m, 1'b0);
      check_output("midrst_busy",      busy_m,  1'b0);
      q_m.delete();
      q_l.delete();
      det_len = 0;
      @(negedge clk);
      rst_n = 1'b1;
      apply_stimulus(1'b1, 8'hC3);
      for (int i = 0; i < P + 2; i++) apply_stimulus(1'b0, 8'h00);

      // Randomised traffic against the model
      for (int i = 0; i < 400; i++) begin
         apply_stimulus(($urandom % 4) != 0, W'($urandom));
      end
      for (int i = 0; i < P + 2; i++) apply_stimulus(1'b0, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
Parallel-to-serial front end that feeds the "001" sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on sout, which drives the detector's inp. sout_valid qualifies each bit. sout idles high between words, so no false 0-0-1 pattern reaches the detector.

Parameters:
WIDTH, 8, word width in bits (2..32)
MSB_FIRST, 1, 1 = shift out din[WIDTH-1] first; 0 = shift out din[0] first

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
din  input  WIDTH  parallel word to serialise
din_valid  input  1  din holds a word to transfer
din_ready  output  1  block can accept a word this cycle
sout  output  1  serial bit to the detector inp; 1 when idle
sout_valid  output  1  sout carries a data (or parity) bit
busy  output  1  a word is in flight (state != IDLE)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, shift register=0, bit counter=0, sout=1, sout_valid=0, busy=0, din_ready=1. On release, start in IDLE at the next edge.
- All outputs except din_ready are registered. din_ready is combinational from state and counter only, never from din_valid.
- A transfer happens on a clock edge where din_valid && din_ready.
- States:
  - IDLE: din_ready=1. On transfer, load the shift register, set the counter to WIDTH-1 and go to SHIFT. Otherwise stay.
  - SHIFT: each edge drives the next bit onto sout with sout_valid=1 and decrements the counter. din_ready=1 only while counter==0, i.e. during the last bit. A transfer in that cycle reloads the register and stays in SHIFT, giving a gapless back-to-back stream. With no transfer in that cycle, go to IDLE.
- Latency: word accepted at edge N; its first bit appears on sout after edge N and is valid in cycle N+1. The last bit is valid in cycle N+WIDTH.
- Bit order: MSB_FIRST=1 shifts left and outputs the top bit. MSB_FIRST=0 shifts right and outputs bit 0.
- Return to IDLE: the edge that leaves SHIFT sets sout=1 and sout_valid=0.
- din is sampled only on a transfer edge. Changes on din at any other time are ignored.
- Counter width: $clog2(WIDTH); it must not wrap below 0.
- Reset mid-word: the word is abandoned immediately and there is no partial output. sout returns to 1 asynchronously.
- din_valid held high with a constant din: the same word repeats back-to-back indefinitely.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined: adds a PARITY state after the last data bit. That state outputs the even-parity bit (XOR of the word) with sout_valid=1 for one cycle. din_ready moves from the last data bit to the PARITY cycle, so back-to-back period = WIDTH+1 cycles.
- Undefined: no PARITY state; period = WIDTH cycles.

Decomposition:
- Shared package seq_pkg holds:
  - state typedef: IDLE=2'b00, SHIFT=2'b01, PARITY=2'b10
  - constant SER_IDLE_LEVEL=1'b1
- No sub-module is needed; the shift register and counter stay inline.
- For bench use, the top-level test wrapper instantiates seq_bit_serializer feeding the detector.

Test Plan:
- Reset release, din_valid=0 for 10 cycles -> sout=1, sout_valid=0, din_ready=1 throughout; detector det never asserts.
- WIDTH=8, MSB_FIRST=1, din=8'h20 accepted at edge N -> sout 0,0,1,0,0,0,0,0 in cycles N+1..N+8 with sout_valid=1; detector det=1 exactly once (cycle N+3); IDLE at N+9.
- Back-to-back: din=8'h01 then 8'hFF with din_valid held -> 16 contiguous valid bits with no gap; din_ready high only in cycles N+8 and N+16.
- MSB_FIRST=0, din=8'hB4 -> sout 0,0,1,0,1,1,0,1.
- rst_n pulled low at cycle N+4 of a word -> sout=1 and sout_valid=0 immediately (asynchronously); after release the next accepted word serialises from its first bit.
- SER_PARITY_EN defined, din=8'h07 -> 8 data bits then parity bit 1 in cycle N+9; din_ready high in cycle N+9 only.
